decode_req_scheduler: RTL and testbench

- Shares one one-hot decode datapath among NUM_REQ requesters. The datapath decodes an index plus an enable into a FANOUT-bit output registered on every clk.
- Round-robin arbitration picks one request at a time. The block drives the datapath's index and enable inputs and captures the registered decode result.
- It reports per-request completion, checking that the result is exactly one-hot at the requested index.
- CRIT_INDEX is a two-cycle path, so the block holds the datapath inputs for one extra cycle on that index.

---
 rtl/decode_sched_pkg.sv | 16 +
 rtl/decode_req_scheduler_rr_arbiter.sv | 29 ++
 rtl/decode_req_scheduler.sv | 132 +++++++++++++
 tb/tb_decode_req_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_sched_pkg.sv
// Shared types and latency constants for the decode request scheduler.
package decode_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLD    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Grant-to-done latencies in clk cycles.
  localparam int LAT_NORMAL = 3;
  localparam int LAT_CRIT   = 4;
  localparam int LAT_ERR    = 1;

endpackage

// File: rtl/decode_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gid,
  output logic               any
);

  always_comb begin
    logic [ID_W-1:0] cand;
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        gid         = cand;
      end
    end
  end

endmodule

// File: rtl/decode_req_scheduler.sv
// Round-robin scheduler sharing one registered one-hot decode datapath among
// NUM_REQ requesters, with a one-cycle hold on the multicycle CRIT_INDEX path.
module decode_req_scheduler
  import decode_sched_pkg::*;
#(
  parameter int FANOUT     = 64,
  parameter int IO_SIZE    = $clog2(FANOUT),
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int CRIT_INDEX = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IO_SIZE-1:0] req_index,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [IO_SIZE-1:0]         dec_inpBus,
  output logic                       dec_enable,
  input  logic [FANOUT-1:0]          dec_outBus,
  output logic                       done_valid,
  output logic [ID_W-1:0]            done_id,
  output logic                       done_hit,
  output logic                       done_err,
  output logic                       busy
);

  localparam logic [IO_SIZE:0]   FANOUT_L = (IO_SIZE+1)'(FANOUT);
  localparam logic [IO_SIZE-1:0] CRIT_L   = IO_SIZE'(CRIT_INDEX);

  function automatic logic [FANOUT-1:0] onehot(input logic [IO_SIZE-1:0] i);
    return FANOUT'(1) << i;
  endfunction

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id_q;
  logic [IO_SIZE-1:0]  idx_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gid;
  logic                any;
  logic [IO_SIZE-1:0]  idx_in;
  logic                in_range;
  logic                take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  always_comb begin
    idx_in = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) idx_in = req_index[r*IO_SIZE +: IO_SIZE];
    end
  end

  assign in_range = {1'b0, idx_in} < FANOUT_L;

  // Grant is Mealy in IDLE; reset masks it because state alone reads as IDLE.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    take       = 1'b0;
    dec_enable = 1'b0;
    case (state)
      IDLE: begin
        if (any && !reset) begin
          req_ready = grant;
          take      = 1'b1;
          state_nxt = in_range ? ISSUE : IDLE;
        end
      end
      ISSUE: begin
        dec_enable = 1'b1;
        state_nxt  = (idx_q == CRIT_L) ? HOLD : CAPTURE;
      end
      HOLD: begin
        dec_enable = 1'b1;
        state_nxt  = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dec_inpBus = idx_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant latch, pointer and registered completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      idx_q      <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_hit   <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      done_hit   <= 1'b0;
      done_err   <= 1'b0;
      if (take) begin
        ptr   <= gid;
        id_q  <= gid;
        idx_q <= idx_in;
        if (!in_range) begin
          done_valid <= 1'b1;
          done_err   <= 1'b1;
          done_id    <= gid;
        end
      end
      if (state == CAPTURE) begin
        done_valid <= 1'b1;
        done_hit   <= (dec_outBus == onehot(idx_q));
        done_id    <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_decode_req_scheduler.sv
// Bench for decode_req_scheduler: two instances (FANOUT 64 and 48) checked
// cycle by cycle against a transaction-level grant/latency model.
module tb_decode_req_scheduler;
  import decode_sched_pkg::*;

  localparam int NR = 4;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid  [2];
  logic [NR*IW-1:0] req_index  [2];
  logic [NR-1:0]    req_ready  [2];
  logic [IW-1:0]    dec_inp    [2];
  logic             dec_en     [2];
  logic             done_valid [2];
  logic [1:0]       done_id    [2];
  logic             done_hit   [2];
  logic             done_err   [2];
  logic             busy       [2];
  logic [63:0]      dp0;
  logic [47:0]      dp1;
  bit               fault_on = 1'b0;

  decode_req_scheduler #(.FANOUT(64), .IO_SIZE(IW), .NUM_REQ(NR), .ID_W(2), .CRIT_INDEX(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_index(req_index[0]),
    .req_ready(req_ready[0]), .dec_inpBus(dec_inp[0]), .dec_enable(dec_en[0]),
    .dec_outBus(dp0), .done_valid(done_valid[0]), .done_id(done_id[0]),
    .done_hit(done_hit[0]), .done_err(done_err[0]), .busy(busy[0]));

  decode_req_scheduler #(.FANOUT(48), .IO_SIZE(IW), .NUM_REQ(NR), .ID_W(2), .CRIT_INDEX(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_index(req_index[1]),
    .req_ready(req_ready[1]), .dec_inpBus(dec_inp[1]), .dec_enable(dec_en[1]),
    .dec_outBus(dp1), .done_valid(done_valid[1]), .done_id(done_id[1]),
    .done_hit(done_hit[1]), .done_err(done_err[1]), .busy(busy[1]));

  // Registered decode datapaths; fault_on adds a stray bit 9 when decoding index 7.
  always @(posedge clk) begin
    dp0 <= dec_en[0] ? ((64'd1 << dec_inp[0]) | ((fault_on && dec_inp[0] == 6'd7) ? 64'h200 : 64'h0)) : 64'h0;
    dp1 <= dec_en[1] ? ((48'd1 << dec_inp[1]) | ((fault_on && dec_inp[1] == 6'd7) ? 48'h200 : 48'h0)) : 48'h0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model state, one slot per instance.
  int  cyc = 0;
  int  next_idle [2];
  int  grant_cyc [2];
  int  glat      [2];
  int  done_at   [2];
  int  sched_id  [2];
  bit  sched_hit [2];
  bit  sched_err [2];
  int  shown_id  [2];
  int  cur_idx   [2];
  int  ptr       [2];
  bit  pend      [2][NR];
  int  pidx      [2][NR];
  bit  hold_all = 1'b0;
  bit  rand_on  = 1'b0;
  bit  log_order = 1'b0;
  int  order_q [$];

  function automatic int fan(input int k);
    return (k == 0) ? 64 : 48;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      next_idle[k] = cyc;
      grant_cyc[k] = -10;
      glat[k]      = LAT_NORMAL;
      done_at[k]   = -1;
      shown_id[k]  = 0;
      cur_idx[k]   = 0;
      ptr[k]       = NR - 1;
      for (int r = 0; r < NR; r++) pend[k][r] = 1'b0;
    end
  endtask

  task automatic request(input int r, input int idx);
    for (int k = 0; k < 2; k++) begin
      pend[k][r] = 1'b1;
      pidx[k][r] = idx;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NR; r++) begin
        req_valid[k][r]          = pend[k][r];
        req_index[k][r*IW +: IW] = IW'(pidx[k][r]);
      end
    @(negedge clk);
    if (log_order)
      for (int r = 0; r < NR; r++) if (req_ready[0][r]) order_q.push_back(r);
    for (int k = 0; k < 2; k++) begin
      bit idle;
      bit exp_en;
      bit is_done;
      int w;
      idle = (cyc >= next_idle[k]);
      w = -1;
      if (idle)
        for (int i = 1; i <= NR; i++)
          if (w < 0 && pend[k][(ptr[k] + i) % NR]) w = (ptr[k] + i) % NR;
      check($sformatf("ready%0d@%0d", k, cyc), 64'(req_ready[k]), (w >= 0) ? 64'(1) << w : 64'h0);
      exp_en = (cyc > grant_cyc[k]) && (cyc <= grant_cyc[k] + glat[k] - 2);
      check($sformatf("enable%0d@%0d", k, cyc), 64'(dec_en[k]), 64'(exp_en));
      check($sformatf("busy%0d@%0d", k, cyc), 64'(busy[k]), 64'(!idle));
      if (!idle) check($sformatf("inpbus%0d@%0d", k, cyc), 64'(dec_inp[k]), 64'(cur_idx[k]));
      is_done = (cyc == done_at[k]);
      if (is_done) shown_id[k] = sched_id[k];
      check($sformatf("done_valid%0d@%0d", k, cyc), 64'(done_valid[k]), 64'(is_done));
      check($sformatf("done_hit%0d@%0d", k, cyc), 64'(done_hit[k]), 64'(is_done && sched_hit[k]));
      check($sformatf("done_err%0d@%0d", k, cyc), 64'(done_err[k]), 64'(is_done && sched_err[k]));
      check($sformatf("done_id%0d@%0d", k, cyc), 64'(done_id[k]), 64'(shown_id[k]));
      if (w >= 0) begin
        bit err;
        ptr[k]       = w;
        grant_cyc[k] = cyc;
        cur_idx[k]   = pidx[k][w];
        err          = (cur_idx[k] >= fan(k));
        glat[k]      = err ? LAT_ERR : (cur_idx[k] == 0) ? LAT_CRIT : LAT_NORMAL;
        next_idle[k] = cyc + glat[k];
        done_at[k]   = cyc + glat[k];
        sched_id[k]  = w;
        sched_err[k] = err;
        sched_hit[k] = !err && !(fault_on && cur_idx[k] == 7);
        if (!hold_all) pend[k][w] = 1'b0;
      end
      if (rand_on)
        for (int r = 0; r < NR; r++)
          if (!pend[k][r] && $urandom_range(0, 2) == 0) begin
            pend[k][r] = 1'b1;
            pidx[k][r] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
          end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int exp_order [5];
    bit found;
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '1;
      req_index[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ready%0d", k), 64'(req_ready[k]), 64'h0);
      check($sformatf("rst_enable%0d", k), 64'(dec_en[k]), 64'h0);
      check($sformatf("rst_inpbus%0d", k), 64'(dec_inp[k]), 64'h0);
      check($sformatf("rst_done%0d", k), 64'({done_valid[k], done_id[k], done_hit[k], done_err[k]}), 64'h0);
      check($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'h0);
      req_valid[k] = '0;
    end
    reset = 1'b0;
    model_reset();

    request(0, 5);
    run(6);
    request(2, 0);
    run(7);
    request(3, 50);
    run(5);

    hold_all  = 1'b1;
    log_order = 1'b1;
    for (int r = 0; r < NR; r++) request(r, r + 1);
    run(13);
    hold_all  = 1'b0;
    log_order = 1'b0;
    run(14);
    check("rr_order_len", 64'(order_q.size() >= 5), 64'h1);
    if (order_q.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_order[%0d]", i), 64'(order_q[i]), 64'(exp_order[i]));

    fault_on = 1'b1;
    request(1, 7);
    run(5);
    fault_on = 1'b0;

    request(2, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (glat[0] == LAT_CRIT && cyc - 1 == grant_cyc[0] + 2) found = 1'b1;
    end
    check("hold_reached", 64'(found), 64'h1);
    for (int k = 0; k < 2; k++) req_valid[k] = '1;
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_ready%0d", k), 64'(req_ready[k]), 64'h0);
      check($sformatf("arst_enable%0d", k), 64'(dec_en[k]), 64'h0);
      check($sformatf("arst_inpbus%0d", k), 64'(dec_inp[k]), 64'h0);
      check($sformatf("arst_done%0d", k), 64'({done_valid[k], done_id[k], done_hit[k], done_err[k]}), 64'h0);
      check($sformatf("arst_busy%0d", k), 64'(busy[k]), 64'h0);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) req_valid[k] = '0;
    reset = 1'b0;
    model_reset();
    for (int r = 0; r < NR; r++) request(r, 10 + r);
    run(14);

    rand_on = 1'b1;
    run(400);
    rand_on = 1'b0;
    run(24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
